// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit: op codes,
// FSM states, fast-path constants and operand signedness helpers.
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [31:0] DIV0_Q       = 32'hFFFF_FFFF;
    localparam logic [31:0] OVF_DIVIDEND = 32'h8000_0000;
    localparam logic [4:0]  ITER_LAST    = 5'd31;

    function automatic logic op_a_signed(input logic [2:0] f);
        case (f)
            OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

    function automatic logic op_b_signed(input logic [2:0] f);
        case (f)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module muldiv_div_step (
    input  logic [31:0] rem,
    input  logic        dbit,
    input  logic [31:0] divisor,
    output logic [31:0] rem_next,
    output logic        q_bit
);

    logic [32:0] diff_s;

    // Trial subtraction; the partial remainder is always below the divisor,
    // so the 33-bit difference sign decides the quotient bit.
    always_comb begin
        diff_s = {rem, dbit} - {1'b0, divisor};
        if (diff_s[32]) begin
            rem_next = {rem[30:0], dbit};
            q_bit    = 1'b0;
        end else begin
            rem_next = diff_s[31:0];
            q_bit    = 1'b1;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (shift-add multiply, restoring divide).
// Define MULDIV_DIV_EN to build the divide datapath; otherwise divides are illegal.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_addr,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            illegal
);

    state_t      state_r, state_s;
    logic [4:0]  cnt_r;
    logic [2:0]  op_r;
    logic        neg_a_r, neg_b_r;
    logic [31:0] aux_r;
    logic [63:0] prod_r;
    logic [31:0] result_r;
    logic [4:0]  rd_r;
    logic        illegal_r;

    logic        a_neg_s, b_neg_s, is_div_s;
    logic [31:0] a_mag_s, b_mag_s;
    logic        fast_s, fast_ill_s;
    logic [31:0] fast_res_s;
    logic [32:0] mul_sum_s;
    logic [63:0] mul_next_s;
    logic [63:0] prod_fix_s;
    logic [31:0] fix_res_s;

    // Operand magnitudes and sign flags captured when a request is accepted.
    always_comb begin
        a_neg_s  = op_a_signed(funct3) & rs1_val[31];
        b_neg_s  = op_b_signed(funct3) & rs2_val[31];
        a_mag_s  = a_neg_s ? (32'd0 - rs1_val) : rs1_val;
        b_mag_s  = b_neg_s ? (32'd0 - rs2_val) : rs2_val;
        is_div_s = funct3[2];
    end

`ifdef MULDIV_DIV_EN
    logic        div0_s, ovf_s;
    logic [31:0] rem_next_s;
    logic        q_bit_s;

    muldiv_div_step u_div_step (
        .rem      (prod_r[63:32]),
        .dbit     (prod_r[31]),
        .divisor  (aux_r),
        .rem_next (rem_next_s),
        .q_bit    (q_bit_s)
    );

    // Divide-by-zero and signed overflow resolve without iterating.
    always_comb begin
        div0_s     = (rs2_val == 32'd0);
        ovf_s      = ((funct3 == OP_DIV) || (funct3 == OP_REM)) &&
                     (rs1_val == OVF_DIVIDEND) && (rs2_val == 32'hFFFF_FFFF);
        fast_ill_s = 1'b0;
        if (is_div_s && div0_s) begin
            fast_s     = 1'b1;
            fast_res_s = funct3[1] ? rs1_val : DIV0_Q;
        end else if (ovf_s) begin
            fast_s     = 1'b1;
            fast_res_s = funct3[1] ? 32'd0 : OVF_DIVIDEND;
        end else begin
            fast_s     = 1'b0;
            fast_res_s = 32'd0;
        end
    end
`else
    // Without the divider every divide/remainder op is rejected immediately.
    always_comb begin
        fast_res_s = 32'd0;
        if (is_div_s) begin
            fast_s     = 1'b1;
            fast_ill_s = 1'b1;
        end else begin
            fast_s     = 1'b0;
            fast_ill_s = 1'b0;
        end
    end
`endif

    // Shift-add step: add the multiplicand into the high half when the
    // current multiplier bit (LSB) is set, then shift the whole product right.
    always_comb begin
        mul_sum_s = {1'b0, prod_r[63:32]} + {1'b0, aux_r};
        if (prod_r[0]) begin
            mul_next_s = {mul_sum_s, prod_r[31:1]};
        end else begin
            mul_next_s = {1'b0, prod_r[63:1]};
        end
    end

    // Sign correction and result selection.
    always_comb begin
        prod_fix_s = (neg_a_r ^ neg_b_r) ? (64'd0 - prod_r) : prod_r;
        case (op_r)
            OP_MUL:                       fix_res_s = prod_fix_s[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res_s = prod_fix_s[63:32];
`ifdef MULDIV_DIV_EN
            OP_DIV, OP_DIVU:              fix_res_s = prod_fix_s[31:0];
            OP_REM, OP_REMU:              fix_res_s = neg_a_r ? (32'd0 - prod_r[63:32])
                                                              : prod_r[63:32];
`endif
            default:                      fix_res_s = 32'd0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (!start) begin
                    state_s = IDLE;
                end else if (fast_s) begin
                    state_s = DONE;
                end else begin
`ifdef MULDIV_DIV_EN
                    state_s = is_div_s ? DIV : MUL;
`else
                    state_s = MUL;
`endif
                end
            end
            MUL:     state_s = (cnt_r == ITER_LAST) ? FIX : MUL;
`ifdef MULDIV_DIV_EN
            DIV:     state_s = (cnt_r == ITER_LAST) ? FIX : DIV;
`endif
            FIX:     state_s = DONE;
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath registers: capture on accept, iterate, then load the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= 5'd0;
            op_r      <= 3'd0;
            neg_a_r   <= 1'b0;
            neg_b_r   <= 1'b0;
            aux_r     <= 32'd0;
            prod_r    <= 64'd0;
            result_r  <= 32'd0;
            rd_r      <= 5'd0;
            illegal_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        op_r      <= funct3;
                        rd_r      <= rd_addr;
                        neg_a_r   <= a_neg_s;
                        neg_b_r   <= b_neg_s;
                        cnt_r     <= 5'd0;
                        illegal_r <= fast_ill_s;
                        if (fast_s) begin
                            result_r <= fast_res_s;
                        end
                        // Divide: dividend in the low half, divisor aside.
                        // Multiply: multiplier in the low half, multiplicand aside.
                        if (is_div_s) begin
                            prod_r <= {32'd0, a_mag_s};
                            aux_r  <= b_mag_s;
                        end else begin
                            prod_r <= {32'd0, b_mag_s};
                            aux_r  <= a_mag_s;
                        end
                    end
                end
                MUL: begin
                    prod_r <= mul_next_s;
                    cnt_r  <= cnt_r + 5'd1;
                end
`ifdef MULDIV_DIV_EN
                DIV: begin
                    prod_r <= {rem_next_s, prod_r[30:0], q_bit_s};
                    cnt_r  <= cnt_r + 5'd1;
                end
`endif
                FIX: begin
                    result_r <= fix_res_s;
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign busy    = (state_r != IDLE);
    assign done    = (state_r == DONE);
    assign illegal = illegal_r & (state_r == DONE);
    assign result  = result_r;
    assign rd_out  = rd_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: randomized and directed RV32M ops checked
// against a plain-arithmetic reference model; honours MULDIV_DIV_EN.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_val, rs2_val;
    logic [4:0]  rd_addr;
    logic        busy, done, illegal;
    logic [31:0] result;
    logic [4:0]  rd_out;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        ill;
        time         t_done;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .funct3  (funct3),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .rd_addr (rd_addr),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .rd_out  (rd_out),
        .illegal (illegal)
    );

    always #5 clk = ~clk;

    function automatic bit div_enabled();
`ifdef MULDIV_DIV_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Reference: returns {illegal, result}.
    function automatic logic [32:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sub;
        logic [63:0] ua, ub, p;
        logic [31:0] sq;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        sub = $signed(ub);
        if (f[2] && !div_enabled()) return {1'b1, 32'd0};
        case (f)
            3'b000: begin p = sa * sb;  return {1'b0, p[31:0]};  end
            3'b001: begin p = sa * sb;  return {1'b0, p[63:32]}; end
            3'b010: begin p = sa * sub; return {1'b0, p[63:32]}; end
            3'b011: begin p = ua * ub;  return {1'b0, p[63:32]}; end
            3'b100: begin
                if (b == 32'd0) return {1'b0, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'h8000_0000};
                p = sa / sb; sq = p[31:0]; return {1'b0, sq};
            end
            3'b101: return {1'b0, (b == 32'd0) ? 32'hFFFF_FFFF : a / b};
            3'b110: begin
                if (b == 32'd0) return {1'b0, a};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'd0};
                p = sa % sb; sq = p[31:0]; return {1'b0, sq};
            end
            default: return {1'b0, (b == 32'd0) ? a : a % b};
        endcase
    endfunction

    function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && !div_enabled()) return 1;
        if (f[2] && b == 32'd0) return 1;
        if ((f == 3'b100 || f == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Issue one op once the unit is idle and record what it must return.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        int guard;
        logic [32:0] m;
        exp_t e;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("idle_wait", {63'd0, busy}, 64'd0);
        m        = model(f, a, b);
        e.res    = m[31:0];
        e.ill    = m[32];
        e.rd     = rd;
        e.t_done = $time + 10 * latency(f, a, b);
        exp_q.push_back(e);
        start   = 1'b1;
        funct3  = f;
        rs1_val = a;
        rs2_val = b;
        rd_addr = rd;
        @(negedge clk);
        start   = 1'b0;
        funct3  = 3'($urandom);
        rs1_val = $urandom;
        rs2_val = $urandom;
        rd_addr = 5'($urandom);
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", {32'd0, result}, {32'd0, e.res});
                check("rd_out", {59'd0, rd_out}, {59'd0, e.rd});
                check("illegal", {63'd0, illegal}, {63'd0, e.ill});
                check("done_time", 64'($time), 64'(e.t_done));
            end
        end
    end

    initial begin
        logic [2:0]  f;
        logic [31:0] a, b;
        int          guard;
        rst = 1'b1; start = 1'b0; funct3 = 3'd0;
        rs1_val = 32'd0; rs2_val = 32'd0; rd_addr = 5'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy",    {63'd0, busy},    64'd0);
        check("rst_done",    {63'd0, done},    64'd0);
        check("rst_illegal", {63'd0, illegal}, 64'd0);
        check("rst_result",  {32'd0, result},  64'd0);
        check("rst_rd_out",  {59'd0, rd_out},  64'd0);

        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5);
        issue(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1);
        issue(3'b011, 32'h8000_0000, 32'h8000_0000, 5'd2);
        issue(3'b010, 32'h8000_0000, 32'h8000_0000, 5'd3);
        issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd4);
        issue(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6);
        issue(3'b101, 32'd100, 32'd7, 5'd7);
        issue(3'b111, 32'd100, 32'd7, 5'd8);
        issue(3'b100, 32'h1234, 32'd0, 5'd9);
        issue(3'b110, 32'h1234, 32'd0, 5'd10);
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
        issue(3'b000, 32'd3, 32'd4, 5'd0);

        // A start while busy must not disturb the op in flight.
        issue(3'b000, 32'd1000, 32'd1000, 5'd13);
        repeat (8) @(negedge clk);
        start = 1'b1; funct3 = 3'b011; rs1_val = 32'hDEAD_BEEF; rs2_val = 32'h1234_5678; rd_addr = 5'd30;
        @(negedge clk);
        start = 1'b0;

        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom);
            a = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2:       b = $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            issue(f, a, b, 5'($urandom));
        end

        // Reset mid-operation aborts without a done pulse and clears outputs.
        issue(3'b001, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd21);
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd22);
        repeat (18) @(negedge clk);
        exp_q.delete();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy",   {63'd0, busy},   64'd0);
        check("abort_done",   {63'd0, done},   64'd0);
        check("abort_result", {32'd0, result}, 64'd0);
        check("abort_rd_out", {59'd0, rd_out}, 64'd0);
        repeat (40) @(negedge clk);
        issue(3'b000, 32'd3, 32'd4, 5'd23);

        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
